// File: rtl/inta_sequencer.sv
// inta_sequencer: drives the 8259 two-pulse INTA sequence and hands the vector to the CPU.
// Optional PRESENT-state timeout is built when INTA_TIMEOUT_EN is defined.
module inta_sequencer #(
    parameter int INTA_LOW_CYCLES = 2,
    parameter int INTA_GAP_CYCLES = 2,
    parameter int REARM_CYCLES    = 2,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       int_in,
    input  logic       cpu_en,
    input  logic [7:0] d_in,
    output logic       inta_n,
    output logic       vec_valid,
    input  logic       vec_ready,
    output logic [7:0] vec_data,
    output logic       busy,
    output logic [7:0] ack_count,
    output logic       timeout_err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PULSE1  = 3'd1;
    localparam logic [2:0] S_GAP     = 3'd2;
    localparam logic [2:0] S_PULSE2  = 3'd3;
    localparam logic [2:0] S_PRESENT = 3'd4;
    localparam logic [2:0] S_REARM   = 3'd5;

    // One shared phase counter, sized for the longest phase.
    localparam int MAX_LG  = (INTA_LOW_CYCLES > INTA_GAP_CYCLES) ?
                             INTA_LOW_CYCLES : INTA_GAP_CYCLES;
    localparam int MAX_LGR = (MAX_LG > REARM_CYCLES) ? MAX_LG : REARM_CYCLES;
    localparam int MAX_ALL = (MAX_LGR > TIMEOUT_CYCLES) ? MAX_LGR : TIMEOUT_CYCLES;
    localparam int CW      = (MAX_ALL > 1) ? $clog2(MAX_ALL) : 1;

    localparam logic [CW-1:0] LOW_LAST   = CW'(INTA_LOW_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(INTA_GAP_CYCLES - 1);
    localparam logic [CW-1:0] REARM_LAST = CW'(REARM_CYCLES - 1);
`ifdef INTA_TIMEOUT_EN
    localparam logic [CW-1:0] TMO_LAST   = CW'(TIMEOUT_CYCLES - 1);
`endif

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          inta_n_q, inta_n_d;
    logic          valid_q, valid_d;
    logic [7:0]    data_q, data_d;
    logic          busy_q, busy_d;
    logic [7:0]    ack_q, ack_d;
    logic          sync1_q, sync2_q;
`ifdef INTA_TIMEOUT_EN
    logic          tmo_q, tmo_d;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        inta_n_d = inta_n_q;
        valid_d  = valid_q;
        data_d   = data_q;
        ack_d    = ack_q;
`ifdef INTA_TIMEOUT_EN
        tmo_d    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (sync2_q && cpu_en) begin
                    state_d  = S_PULSE1;
                    inta_n_d = 1'b0;
                end
            end
            S_PULSE1: begin
                if (cnt_q == LOW_LAST) begin
                    state_d  = S_GAP;
                    cnt_d    = '0;
                    inta_n_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d  = S_PULSE2;
                    cnt_d    = '0;
                    inta_n_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_PULSE2: begin
                // Vector is latched on the edge that closes the last low cycle.
                if (cnt_q == LOW_LAST) begin
                    state_d  = S_PRESENT;
                    cnt_d    = '0;
                    inta_n_d = 1'b1;
                    valid_d  = 1'b1;
                    data_d   = d_in;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_PRESENT: begin
                if (vec_ready) begin
                    state_d = S_REARM;
                    cnt_d   = '0;
                    valid_d = 1'b0;
                    ack_d   = ack_q + 8'd1;
                end
`ifdef INTA_TIMEOUT_EN
                else if (cnt_q == TMO_LAST) begin
                    state_d = S_REARM;
                    cnt_d   = '0;
                    valid_d = 1'b0;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
`endif
            end
            S_REARM: begin
                if (cnt_q == REARM_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d  = S_IDLE;
                cnt_d    = '0;
                inta_n_d = 1'b1;
                valid_d  = 1'b0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            inta_n_q <= 1'b1;
            valid_q  <= 1'b0;
            data_q   <= 8'h00;
            busy_q   <= 1'b0;
            ack_q    <= 8'h00;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            inta_n_q <= inta_n_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
            ack_q    <= ack_d;
            sync1_q  <= int_in;
            sync2_q  <= sync1_q;
        end
    end

`ifdef INTA_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
        end
    end

    assign timeout_err = tmo_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign inta_n    = inta_n_q;
    assign vec_valid = valid_q;
    assign vec_data  = data_q;
    assign busy      = busy_q;
    assign ack_count = ack_q;

endmodule
